max7219_frame_loader: RTL and testbench

Upstream feeder for `max7219_cmd_decod`. It accepts a stream of 16-bit MAX7219 command words from a host over a valid/ready handshake and writes each word into the decoder's command RAM at a circular write pointer. On commit, it launches the decoder over the written range using `start_ptr`/`last_ptr`/`ptr_val`, with optional looping, and then waits for `ptr_equality` before it accepts the next frame.

---
 rtl/max7219_frame_loader.sv | 155 +++++++++++++++
 tb/tb_max7219_frame_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_frame_loader.sv
// max7219_frame_loader: gathers host command words into the MAX7219 decoder
// RAM at a circular write pointer and launches the decoder over each frame.
module max7219_frame_loader #(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 16,
  parameter int G_EQ_GUARD       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_wr_data,
  input  logic                        i_commit,
  input  logic                        i_loop,
  input  logic                        i_stop,
  output logic                        o_me,
  output logic                        o_we,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
  output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_start_ptr,
  output logic [G_RAM_ADDR_WIDTH-1:0] o_last_ptr,
  output logic                        o_ptr_val,
  output logic                        o_loop,
  output logic                        o_en,
  input  logic                        i_ptr_equality,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [G_RAM_ADDR_WIDTH:0]   o_count
);

  localparam int W = G_RAM_ADDR_WIDTH;
  localparam logic [W:0]   FULL_COUNT = {1'b1, {W{1'b0}}};
  localparam logic [W-1:0] PTR_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE    = {{W{1'b0}}, 1'b1};
  localparam logic [3:0]   GUARD_LOAD = 4'(G_EQ_GUARD);

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, RUN} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] wr_ptr;
  logic [W-1:0] seg_start;
  logic [W:0]   count;
  logic [W:0]   count_nxt;
  logic [3:0]   guard;
  logic         commit_pend;
  logic         commit_pend_nxt;
  logic         latch_frame;
  logic         finish;
  logic         ready_nxt;
  logic         accept;

  assign accept  = i_wr_valid & o_wr_ready;
  assign o_count = count;

  // State register; reset aborts any frame in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a word accepted together with commit delays launch by one cycle
  always_comb begin
    state_nxt       = state;
    commit_pend_nxt = 1'b0;
    latch_frame     = 1'b0;
    finish          = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = FILL;
      end
      FILL: begin
        if (commit_pend) begin
          state_nxt = LAUNCH;
        end else if (i_commit) begin
          latch_frame = 1'b1;
          if (accept) commit_pend_nxt = 1'b1;
          else        state_nxt       = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (!o_loop && i_ptr_equality && (guard == 4'd0)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    count_nxt = count;
    if (finish)      count_nxt = '0;
    else if (accept) count_nxt = count + CNT_ONE;

    ready_nxt = (state_nxt == IDLE) ||
                ((state_nxt == FILL) && !commit_pend_nxt && (count_nxt != FULL_COUNT));
  end

  // Datapath and registered outputs: RAM write port, frame pointers, strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      seg_start   <= '0;
      count       <= '0;
      guard       <= '0;
      commit_pend <= 1'b0;
      o_wr_ready  <= 1'b1;
      o_me        <= 1'b0;
      o_we        <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_start_ptr <= '0;
      o_last_ptr  <= '0;
      o_ptr_val   <= 1'b0;
      o_loop      <= 1'b0;
      o_en        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      count       <= count_nxt;
      commit_pend <= commit_pend_nxt;
      o_wr_ready  <= ready_nxt;
      o_me        <= accept;
      o_we        <= accept;
      if (accept) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        o_addr  <= wr_ptr;
        o_wdata <= i_wr_data;
      end
      if (latch_frame) begin
        o_start_ptr <= seg_start;
        o_last_ptr  <= accept ? wr_ptr : (wr_ptr - PTR_ONE);
        o_loop      <= i_loop;
      end else if ((state == RUN) && i_stop) begin
        o_loop <= 1'b0;
      end
      if ((state == FILL) && (state_nxt == LAUNCH)) begin
        guard <= GUARD_LOAD;
      end else if (guard != 4'd0) begin
        guard <= guard - 4'd1;
      end
      if (finish) seg_start <= wr_ptr;
      o_ptr_val <= (state_nxt == LAUNCH);
      o_en      <= (state_nxt == LAUNCH) || (state_nxt == RUN);
      o_busy    <= (state_nxt != IDLE);
      o_done    <= finish;
    end
  end

endmodule

// File: tb/tb_max7219_frame_loader.sv
// Testbench for max7219_frame_loader: randomized frames checked against a
// transaction-level model of write addresses, frame pointers and run timing.
module tb_max7219_frame_loader;

  localparam int W     = 8;
  localparam int D     = 16;
  localparam int G     = 2;
  localparam int DEPTH = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_wr_valid, i_commit, i_loop, i_stop, i_ptr_equality;
  logic [D-1:0] i_wr_data;
  logic         o_wr_ready, o_me, o_we, o_ptr_val, o_loop, o_en, o_busy, o_done;
  logic [W-1:0] o_addr, o_start_ptr, o_last_ptr;
  logic [D-1:0] o_wdata;
  logic [W:0]   o_count;

  int checks   = 0;
  int failures = 0;

  int exp_ptr   = 0;
  int exp_seg   = 0;
  int exp_count = 0;
  int exp_start = 0;
  int exp_last  = 0;
  bit exp_loop  = 0;
  bit committed = 0;
  bit pend      = 0;
  logic [D-1:0] word_q[$];

  max7219_frame_loader #(
    .G_RAM_ADDR_WIDTH(W),
    .G_RAM_DATA_WIDTH(D),
    .G_EQ_GUARD(G)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .i_commit(i_commit), .i_loop(i_loop), .i_stop(i_stop),
    .o_me(o_me), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_start_ptr(o_start_ptr), .o_last_ptr(o_last_ptr), .o_ptr_val(o_ptr_val),
    .o_loop(o_loop), .o_en(o_en), .i_ptr_equality(i_ptr_equality),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_wr_ready"}, o_wr_ready, 1);
    checkOutput({tag, "_me"}, o_me, 0);
    checkOutput({tag, "_we"}, o_we, 0);
    checkOutput({tag, "_addr"}, o_addr, 0);
    checkOutput({tag, "_wdata"}, o_wdata, 0);
    checkOutput({tag, "_start"}, o_start_ptr, 0);
    checkOutput({tag, "_last"}, o_last_ptr, 0);
    checkOutput({tag, "_ptr_val"}, o_ptr_val, 0);
    checkOutput({tag, "_loop"}, o_loop, 0);
    checkOutput({tag, "_en"}, o_en, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_count"}, o_count, 0);
  endtask

  // One host cycle: check handshake state, drive inputs, then check the RAM write it causes
  task automatic applyStimulus(input bit valid, input bit commit, input bit loop);
    bit           exp_ready;
    bit           acc;
    int           wa;
    logic [D-1:0] d;
    exp_ready = !committed && (exp_count < DEPTH);
    checkOutput("wr_ready", o_wr_ready, exp_ready);
    checkOutput("count", o_count, exp_count);
    d = '0;
    if (valid) d = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
    acc = valid && exp_ready;
    wa  = exp_ptr;
    i_wr_valid = valid;
    i_wr_data  = d;
    i_commit   = commit;
    i_loop     = loop;
    if (acc) begin
      exp_ptr = (exp_ptr + 1) % DEPTH;
      exp_count++;
    end
    if (commit) begin
      committed = 1;
      pend      = acc;
      exp_start = exp_seg;
      exp_last  = (exp_ptr + DEPTH - 1) % DEPTH;
      exp_loop  = loop;
    end
    tick();
    i_wr_valid = 0;
    i_commit   = 0;
    i_loop     = 0;
    i_wr_data  = '0;
    checkOutput("ram_me", o_me, acc);
    checkOutput("ram_we", o_we, acc);
    if (acc) begin
      checkOutput("ram_addr", o_addr, wa);
      checkOutput("ram_wdata", o_wdata, d);
    end
  endtask

  task automatic fillFrame(input int n, input bit commit_last, input bit do_commit,
                           input bit loop, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gaps; g++) applyStimulus(0, 0, 0);
      applyStimulus(1, do_commit && commit_last && (i == n - 1), loop);
    end
    if (do_commit && !commit_last) applyStimulus(0, 1, loop);
  endtask

  // Called right after the commit cycle; leaves the bench at the launch-strobe cycle
  task automatic launchCheck();
    if (pend) begin
      checkOutput("ptr_val_after_write", o_ptr_val, 0);
      tick();
      checkOutput("ram_me_at_launch", o_me, 0);
    end
    checkOutput("ptr_val", o_ptr_val, 1);
    checkOutput("start_ptr", o_start_ptr, exp_start);
    checkOutput("last_ptr", o_last_ptr, exp_last);
    checkOutput("loop", o_loop, exp_loop);
    checkOutput("en_launch", o_en, 1);
    checkOutput("busy_launch", o_busy, 1);
    checkOutput("wr_ready_launch", o_wr_ready, 0);
  endtask

  task automatic completeModel();
    exp_seg   = exp_ptr;
    exp_count = 0;
    committed = 0;
    pend      = 0;
  endtask

  // Equality held from cycle eq_from (0 = launch cycle); done one cycle after it first counts
  task automatic runAndComplete(input int eq_from);
    int done_at;
    done_at = ((eq_from > G) ? eq_from : G) + 1;
    for (int k = 1; k <= done_at; k++) begin
      i_ptr_equality = (k - 1 >= eq_from);
      tick();
      checkOutput("done", o_done, (k == done_at));
      if (k == 1) checkOutput("ptr_val_one_cycle", o_ptr_val, 0);
      if (k < done_at) begin
        checkOutput("en_run", o_en, 1);
        checkOutput("busy_run", o_busy, 1);
      end
    end
    i_ptr_equality = 0;
    checkOutput("en_after_done", o_en, 0);
    checkOutput("busy_after_done", o_busy, 0);
    checkOutput("count_after_done", o_count, 0);
    checkOutput("ready_after_done", o_wr_ready, 1);
    checkOutput("start_stable", o_start_ptr, exp_start);
    checkOutput("last_stable", o_last_ptr, exp_last);
    completeModel();
    tick();
    checkOutput("done_one_cycle", o_done, 0);
  endtask

  task automatic runLoop(input int pulses);
    for (int p = 0; p < pulses; p++) begin
      i_ptr_equality = 1;
      tick();
      i_ptr_equality = 0;
      checkOutput("loop_no_done", o_done, 0);
      checkOutput("loop_held", o_loop, 1);
      tick();
      checkOutput("loop_no_done", o_done, 0);
      checkOutput("en_loop", o_en, 1);
    end
    i_stop = 1;
    tick();
    i_stop = 0;
    checkOutput("loop_cleared", o_loop, 0);
    checkOutput("stop_no_done", o_done, 0);
    i_ptr_equality = 1;
    tick();
    i_ptr_equality = 0;
    checkOutput("loop_done", o_done, 1);
    checkOutput("loop_busy_after", o_busy, 0);
    checkOutput("loop_start_stable", o_start_ptr, exp_start);
    checkOutput("loop_last_stable", o_last_ptr, exp_last);
    completeModel();
    tick();
    checkOutput("loop_done_one_cycle", o_done, 0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    i_wr_valid = 0; i_wr_data = '0; i_commit = 0; i_loop = 0; i_stop = 0; i_ptr_equality = 0;
    tick();
    tick();
    checkResetValues("reset");
    rst_n = 1;
    tick();

    // Fixed three-word frame, equality ten cycles after launch
    word_q = '{16'h0C01, 16'h0F00, 16'h0A08};
    fillFrame(3, 0, 1, 0, 0);
    launchCheck();
    checkOutput("t1_start", o_start_ptr, 0);
    checkOutput("t1_last", o_last_ptr, 2);
    runAndComplete(10);

    // Second frame continues at address 3
    fillFrame(2, 0, 1, 0, 1);
    launchCheck();
    checkOutput("t2_start", o_start_ptr, 3);
    checkOutput("t2_last", o_last_ptr, 4);
    runAndComplete($urandom_range(0, 6));

    // Equality high from launch: done exactly G+1 cycles later
    fillFrame(4, 1, 1, 0, 0);
    launchCheck();
    runAndComplete(0);

    // Looping frame
    fillFrame(3, 0, 1, 1, 0);
    launchCheck();
    runLoop(3);

    // Random frames
    repeat (8) begin
      bit lp;
      lp = ($urandom_range(0, 3) == 0);
      fillFrame($urandom_range(1, 10), $urandom_range(0, 1), 1, lp, 2);
      launchCheck();
      if (lp) runLoop($urandom_range(1, 3));
      else    runAndComplete($urandom_range(0, 8));
    end

    // Advance the write pointer to 0xFE, then wrap
    n = (254 - exp_ptr + DEPTH) % DEPTH;
    if (n > 0) begin
      fillFrame(n, 1, 1, 0, 0);
      launchCheck();
      runAndComplete(G);
    end
    fillFrame(3, 0, 1, 0, 0);
    launchCheck();
    checkOutput("wrap_start", o_start_ptr, 8'hFE);
    checkOutput("wrap_last", o_last_ptr, 8'h00);
    runAndComplete(1);

    // Full frame: ready drops at 2^W words and further words are refused
    fillFrame(DEPTH, 0, 0, 0, 0);
    checkOutput("full_count", o_count, DEPTH);
    checkOutput("full_ready", o_wr_ready, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    launchCheck();
    checkOutput("full_last", o_last_ptr, (exp_seg + DEPTH - 1) % DEPTH);
    runAndComplete(3);

    // Full frame with commit on the final word
    fillFrame(DEPTH, 1, 1, 0, 0);
    launchCheck();
    runAndComplete(2);

    // Asynchronous reset during a run
    fillFrame(2, 0, 1, 0, 0);
    launchCheck();
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    checkResetValues("async_reset");
    i_ptr_equality = 1;
    repeat (3) begin
      tick();
      checkOutput("no_done_in_reset", o_done, 0);
    end
    rst_n = 1;
    exp_ptr = 0; exp_seg = 0; exp_count = 0; committed = 0; pend = 0;
    tick();
    i_ptr_equality = 0;
    checkOutput("no_done_after_reset", o_done, 0);
    fillFrame(2, 0, 1, 0, 0);
    launchCheck();
    checkOutput("t6_start", o_start_ptr, 0);
    checkOutput("t6_last", o_last_ptr, 1);
    runAndComplete(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
